sync_debounce: RTL and testbench

SYNC_DEBOUNCE -- requirements
Module: sync_debounce

---
 rtl/sync_debounce.sv | 97 +++++++++
 tb/tb_sync_debounce.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce.sv
// sync_debounce: SYNC_STAGES-flop synchronizer with an optional debounce filter.
// Define SYNC_DEBOUNCE_FILTER_EN to build the filter; otherwise clean_data follows the synchronizer.
module sync_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic       sample_clk,
  input  logic       reset,
  input  logic       async_in,
  output logic       clean_data,
  output logic       busy,
  output logic [7:0] glitch_count
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("sync_debounce: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce_cycles
    $error("sync_debounce: DEBOUNCE_CYCLES must be 2..65535");
  end

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_out;

  // Only the next stage reads an intermediate flop; the last stage is the sole consumer tap.
  always_ff @(posedge sample_clk) begin
    if (!reset) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_ff[SYNC_STAGES-1];

`ifdef SYNC_DEBOUNCE_FILTER_EN
  localparam int unsigned CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE,
    PENDING
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge sample_clk) begin
    if (!reset) begin
      state        <= STABLE;
      cnt          <= '0;
      clean_data   <= 1'b0;
      busy         <= 1'b0;
      glitch_count <= '0;
    end else begin
      case (state)
        STABLE: begin
          if (sync_out != clean_data) begin
            state <= PENDING;
            cnt   <= CNT_W'(1);
            busy  <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        PENDING: begin
          if (sync_out == clean_data) begin
            state <= STABLE;
            cnt   <= '0;
            busy  <= 1'b0;
            if (glitch_count != '1) begin
              glitch_count <= glitch_count + 8'd1;
            end
          end else if (cnt == CNT_LAST) begin
            clean_data <= sync_out;
            state      <= STABLE;
            cnt        <= '0;
            busy       <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
`else
  assign clean_data   = sync_out;
  assign busy         = 1'b0;
  assign glitch_count = '0;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Scoreboard bench for sync_debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=4); expectations follow
// SYNC_DEBOUNCE_FILTER_EN the same way the design does.
module tb_sync_debounce;
  localparam int S = 2;
  localparam int D = 4;

  logic       sample_clk = 1'b0;
  logic       reset      = 1'b0;
  logic       async_in   = 1'b0;
  logic       clean_data;
  logic       busy;
  logic [7:0] glitch_count;

  sync_debounce #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .sample_clk  (sample_clk),
    .reset       (reset),
    .async_in    (async_in),
    .clean_data  (clean_data),
    .busy        (busy),
    .glitch_count(glitch_count)
  );

  always #5 sample_clk = ~sample_clk;

  typedef struct {
    int         cyc;
    logic       clean;
    logic       busy;
    logic [7:0] gc;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   edge_n      = 0;
  int   vectors     = 0;
  int   miscompares = 0;

  // Monitor: edge_n counts rising edges; outputs are sampled 1 time unit after each edge.
  initial begin
    forever begin
      @(posedge sample_clk);
      #1;
      edge_n++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc <= edge_n) begin
          vectors++;
          if (sb[i].cyc < edge_n) begin
            miscompares++;
            $display("FAIL %s: check for edge %0d was missed (now edge %0d)", sb[i].tag, sb[i].cyc, edge_n);
          end else if ({clean_data, busy, glitch_count} !== {sb[i].clean, sb[i].busy, sb[i].gc}) begin
            miscompares++;
            $display("FAIL %s @edge %0d: clean/busy/gc got %b/%b/%0d, expected %b/%b/%0d",
                     sb[i].tag, edge_n, clean_data, busy, glitch_count,
                     sb[i].clean, sb[i].busy, sb[i].gc);
          end
          sb.delete(i);
        end
      end
    end
  end

  task automatic push(input int cyc, input logic c, input logic b, input logic [7:0] g,
                      input string tag);
    exp_t e;
    e.cyc   = cyc;
    e.clean = c;
    e.busy  = b;
    e.gc    = g;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sample_clk);
  endtask

  // Expected response to a steady level change first sampled at edge b+1.
  task automatic step_expect(input int b, input logic from_lvl, input logic to_lvl, input string tag);
`ifdef SYNC_DEBOUNCE_FILTER_EN
    push(b + S, from_lvl, 1'b0, 8'd0, tag);
    for (int k = S + 1; k < S + D; k++) push(b + k, from_lvl, 1'b1, 8'd0, tag);
    push(b + S + D, to_lvl, 1'b0, 8'd0, tag);
`else
    push(b + S - 1, from_lvl, 1'b0, 8'd0, tag);
    push(b + S, to_lvl, 1'b0, 8'd0, tag);
`endif
  endtask

  task automatic do_reset(input logic lvl, input int n);
    reset    = 1'b0;
    async_in = lvl;
    cycles(n);
    reset = 1'b1;
  endtask

  initial begin
    int t0;
    cycles(1);

    // Reset held with async_in high, then rise after release.
    reset    = 1'b0;
    async_in = 1'b1;
    t0       = edge_n;
    for (int k = 1; k <= 3; k++) push(t0 + k, 1'b0, 1'b0, 8'd0, "reset_hold");
    cycles(3);
    reset = 1'b1;
    step_expect(edge_n, 1'b0, 1'b1, "rise_after_reset");
    cycles(8);

    // Clean rising step held 20 cycles, then a clean falling step.
    do_reset(1'b0, 2);
    cycles(3);
    t0       = edge_n;
    async_in = 1'b1;
    step_expect(t0, 1'b0, 1'b1, "rise_step");
    cycles(20);
    push(edge_n + 1, 1'b1, 1'b0, 8'd0, "rise_hold");
    cycles(2);
    t0       = edge_n;
    async_in = 1'b0;
    step_expect(t0, 1'b1, 1'b0, "fall_step");
    cycles(10);

    // Two-cycle pulse, then one-cycle pulse.
    t0       = edge_n;
    async_in = 1'b1;
`ifdef SYNC_DEBOUNCE_FILTER_EN
    push(t0 + 2, 1'b0, 1'b0, 8'd0, "pulse2");
    push(t0 + 3, 1'b0, 1'b1, 8'd0, "pulse2");
    push(t0 + 4, 1'b0, 1'b1, 8'd0, "pulse2");
    push(t0 + 5, 1'b0, 1'b0, 8'd1, "pulse2");
    push(t0 + 8, 1'b0, 1'b0, 8'd1, "pulse2");
`else
    push(t0 + 2, 1'b1, 1'b0, 8'd0, "pulse2");
    push(t0 + 3, 1'b1, 1'b0, 8'd0, "pulse2");
    push(t0 + 4, 1'b0, 1'b0, 8'd0, "pulse2");
`endif
    cycles(2);
    async_in = 1'b0;
    cycles(8);
    t0       = edge_n;
    async_in = 1'b1;
`ifdef SYNC_DEBOUNCE_FILTER_EN
    push(t0 + 3, 1'b0, 1'b1, 8'd1, "pulse1");
    push(t0 + 4, 1'b0, 1'b0, 8'd2, "pulse1");
`else
    push(t0 + 2, 1'b1, 1'b0, 8'd0, "pulse1");
    push(t0 + 3, 1'b0, 1'b0, 8'd0, "pulse1");
`endif
    cycles(1);
    async_in = 1'b0;
    cycles(6);

    // 300 short glitches: count saturates at 255.
    do_reset(1'b0, 2);
    cycles(2);
    for (int n = 1; n <= 300; n++) begin
      async_in = 1'b1;
      cycles(1);
      async_in = 1'b0;
      cycles(3);
      if (n == 100 || n == 254 || n == 255 || n == 256 || n == 300) begin
`ifdef SYNC_DEBOUNCE_FILTER_EN
        push(edge_n + 1, 1'b0, 1'b0, (n > 255) ? 8'd255 : 8'(n), "glitch_sat");
`else
        push(edge_n + 1, 1'b0, 1'b0, 8'd0, "glitch_sat");
`endif
      end
    end
    cycles(4);

    // Reset asserted mid-qualification, then re-qualify after release.
    do_reset(1'b0, 2);
    cycles(3);
    t0       = edge_n;
    async_in = 1'b1;
`ifdef SYNC_DEBOUNCE_FILTER_EN
    push(t0 + 3, 1'b0, 1'b1, 8'd0, "busy_before_rst");
`else
    push(t0 + 3, 1'b1, 1'b0, 8'd0, "busy_before_rst");
`endif
    cycles(3);
    reset = 1'b0;
    push(t0 + 4, 1'b0, 1'b0, 8'd0, "rst_mid_pending");
    cycles(1);
    reset = 1'b1;
    step_expect(edge_n, 1'b0, 1'b1, "rise_after_abort");
    cycles(10);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge sample_clk);
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations still queued, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
